// File: rtl/riscv_pkg.sv
// Fetch-path constants shared by the IF stage and the state type of its flush FSM.
package riscv_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with clear; head word visible on data_o without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// IF-stage front end: fetch PC, in-order imem requests and a prefetch queue feeding IF/ID.
// Redirects flush the queue and discard responses to requests issued before the redirect.
module instr_fetch_queue #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  import riscv_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = XLEN + INSTR_W;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             req_fire, rsp_fire, rsp_keep, rsp_drop;
  logic [CNT_W-1:0] occ;
  logic             data_full, data_empty, data_push, data_pop;
  logic [ENT_W-1:0] data_in, data_head;
  logic [XLEN-1:0]  tag_head;
  logic             tag_full, tag_empty, tag_push, tag_pop;
  logic [CNT_W-1:0] tag_count;
  logic             unused_fifo_status;

  // Buffered plus in-flight words may never exceed the queue, so responses always fit.
  assign imem_req_valid = !reset && ((SUM_W'(occ) + SUM_W'(out_q)) < SUM_W'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (out_q != '0);
  assign rsp_drop = rsp_fire && (state_q == FETCH_FLUSH);
  assign rsp_keep = rsp_fire && (state_q == FETCH_RUN);

  // Next-state for PC, counters and the RUN/FLUSH FSM; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_d  = drop_q;

    if (req_fire) pc_d = pc_q + XLEN'(4);
    if (rsp_drop) drop_d = drop_q - CNT_W'(1);

    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = out_d;
    end

    case (state_q)
      FETCH_RUN:   if (redirect_valid && (out_d != '0)) state_d = FETCH_FLUSH;
      FETCH_FLUSH: if (drop_d == '0) state_d = FETCH_RUN;
      default:     state_d = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  // Tags cover only requests that survive the latest redirect.
  assign tag_push = req_fire && !redirect_valid;
  assign tag_pop  = rsp_keep && !tag_empty;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .data_i  (pc_q),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  assign data_push = rsp_keep && !redirect_valid;
  assign data_pop  = if_valid && !stall && !redirect_valid;
  assign data_in   = {tag_head, imem_rsp_data};

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (data_push),
    .pop_i   (data_pop),
    .data_i  (data_in),
    .data_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (occ)
  );

  assign unused_fifo_status = ^{data_full, tag_full, tag_count};

  assign if_valid = !data_empty;
  assign if_pc    = if_valid ? data_head[ENT_W-1:INSTR_W] : '0;
  assign if_instr = if_valid ? data_head[INSTR_W-1:0] : NOP_INSTR;

endmodule
